// File: rtl/dvc_bus_master.sv
// Device-bus initiator: turns single valid/ready commands into one-cycle load/store
// strobes, captures registered read data, and runs a masked hardware poll loop.
module dvc_bus_master #(
  parameter logic [15:0] POLL_MAX = 16'd1000,
  parameter logic [3:0]  POLL_GAP = 4'd2,
  parameter logic [3:0]  IDLE_CTL = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [31:0] cmd_mask,
  input  logic [31:0] cmd_match,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_timeout,
  output logic        rsp_err,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_mem_ctl,
  output logic [31:0] bus_din,
  input  logic [31:0] bus_dout
);

  localparam logic [3:0] DMEM_SB  = 4'd1;
  localparam logic [3:0] DMEM_SW  = 4'd2;
  localparam logic [3:0] DMEM_LW  = 4'd3;
  localparam logic [3:0] DMEM_LBU = 4'd4;
  localparam logic [3:0] DMEM_LBS = 4'd5;

  localparam logic [2:0] OP_LW   = 3'd0;
  localparam logic [2:0] OP_SW   = 3'd1;
  localparam logic [2:0] OP_LBU  = 3'd2;
  localparam logic [2:0] OP_SB   = 3'd3;
  localparam logic [2:0] OP_POLL = 3'd4;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_CAPT, S_RESP, S_GAP} state_t;

  state_t      r_state, w_next;
  logic [2:0]  r_op;
  logic [31:0] r_addr, r_wdata, r_mask, r_match;
  logic [15:0] r_pollCnt, w_cntNext, w_cntInc;
  logic [3:0]  r_gapCnt, w_gapNext;

  logic        w_accept;
  logic [2:0]  w_issueOp;
  logic [31:0] w_issueAddr, w_issueWdata, w_sample;
  logic [31:0] w_rspData;
  logic        w_rspTo, w_rspErr;
  logic [31:0] w_busAddr, w_busDin;
  logic [3:0]  w_busCtl;

  assign w_cntInc = (r_pollCnt == 16'hFFFF) ? r_pollCnt : r_pollCnt + 16'd1;
  assign w_sample = (r_op == OP_LBU) ? {24'b0, bus_dout[7:0]} : bus_dout;

  // Next state, plus the values every registered output takes on entering that state
  always_comb begin
    w_next       = r_state;
    w_accept     = 1'b0;
    w_issueOp    = r_op;
    w_issueAddr  = r_addr;
    w_issueWdata = r_wdata;
    w_cntNext    = r_pollCnt;
    w_gapNext    = r_gapCnt;
    w_rspData    = 32'b0;
    w_rspTo      = 1'b0;
    w_rspErr     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_accept     = 1'b1;
          w_cntNext    = 16'd0;
          w_issueOp    = cmd_op;
          w_issueAddr  = cmd_addr;
          w_issueWdata = cmd_wdata;
          if (cmd_op <= OP_POLL) begin
            w_next = S_ISSUE;
          end else begin
            w_next   = S_RESP;
            w_rspErr = 1'b1;
          end
        end
      end
      S_ISSUE: w_next = (r_op == OP_SW || r_op == OP_SB) ? S_RESP : S_CAPT;
      S_CAPT: begin
        if (r_op != OP_POLL) begin
          w_next    = S_RESP;
          w_rspData = w_sample;
        end else begin
          w_cntNext = w_cntInc;
          if ((bus_dout & r_mask) == (r_match & r_mask)) begin
            w_next    = S_RESP;
            w_rspData = w_sample;
          end else if (w_cntInc == POLL_MAX) begin
            w_next    = S_RESP;
            w_rspData = w_sample;
            w_rspTo   = 1'b1;
          end else if (POLL_GAP == 4'd0) begin
            w_next = S_ISSUE;
          end else begin
            w_next    = S_GAP;
            w_gapNext = POLL_GAP - 4'd1;
          end
        end
      end
      S_GAP: begin
        if (r_gapCnt == 4'd0) w_next = S_ISSUE;
        else w_gapNext = r_gapCnt - 4'd1;
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Bus drive for the coming cycle; only an ISSUE cycle carries a strobe
  always_comb begin
    w_busAddr = bus_addr;
    w_busCtl  = IDLE_CTL;
    w_busDin  = 32'b0;
    if (w_next == S_ISSUE) begin
      w_busAddr = w_issueAddr;
      case (w_issueOp)
        OP_SW:   begin w_busCtl = DMEM_SW;  w_busDin = w_issueWdata; end
        OP_SB:   begin w_busCtl = DMEM_SB;  w_busDin = {24'b0, w_issueWdata[7:0]}; end
        OP_LBU:  w_busCtl = DMEM_LBU;
        default: w_busCtl = DMEM_LW;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_op        <= OP_LW;
      r_addr      <= 32'b0;
      r_wdata     <= 32'b0;
      r_mask      <= 32'b0;
      r_match     <= 32'b0;
      r_pollCnt   <= 16'd0;
      r_gapCnt    <= 4'd0;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 32'b0;
      rsp_timeout <= 1'b0;
      rsp_err     <= 1'b0;
      bus_addr    <= 32'b0;
      bus_mem_ctl <= IDLE_CTL;
      bus_din     <= 32'b0;
    end else begin
      r_state   <= w_next;
      r_pollCnt <= w_cntNext;
      r_gapCnt  <= w_gapNext;
      if (w_accept) begin
        r_op    <= cmd_op;
        r_addr  <= cmd_addr;
        r_wdata <= cmd_wdata;
        r_mask  <= cmd_mask;
        r_match <= cmd_match;
      end
      cmd_ready   <= (w_next == S_IDLE);
      rsp_valid   <= (w_next == S_RESP);
      rsp_rdata   <= w_rspData;
      rsp_timeout <= w_rspTo;
      rsp_err     <= w_rspErr;
      bus_addr    <= w_busAddr;
      bus_mem_ctl <= w_busCtl;
      bus_din     <= w_busDin;
    end
  end

  // DMEM_LBS is part of the bus code set but this initiator never issues it
  logic w_unusedLbs;
  assign w_unusedLbs = ^DMEM_LBS;

endmodule

// File: tb/tb_dvc_bus_master.sv
// Scoreboard bench for dvc_bus_master: expected strobes and responses are queued
// when a command is issued and popped by negedge monitors.
module tb_dvc_bus_master;

  localparam logic [3:0] IDLE_CTL = 4'd0;
  localparam logic [3:0] DMEM_SB  = 4'd1;
  localparam logic [3:0] DMEM_SW  = 4'd2;
  localparam logic [3:0] DMEM_LW  = 4'd3;
  localparam logic [3:0] DMEM_LBU = 4'd4;

  localparam logic [31:0] CMD_ADDR       = 32'h0000_2000;
  localparam logic [31:0] UART_DATA_ADDR = 32'h0000_3000;
  localparam logic [31:0] STATUS_ADDR    = 32'h0000_3004;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0, cmd_mask = '0, cmd_match = '0;
  logic        rsp_valid, rsp_timeout, rsp_err;
  logic [31:0] rsp_rdata, bus_addr, bus_din;
  logic [3:0]  bus_mem_ctl;
  logic [31:0] bus_dout = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct packed { logic [3:0] ctl; logic [31:0] addr; logic [31:0] din; int cyc; } strobe_t;
  typedef struct packed { logic [31:0] rdata; logic to; logic err; int cyc; } rsp_t;
  strobe_t strobeQ[$];
  rsp_t    rspQ[$];

  // Responder model: registered read data, a queue of poll values, two LED bits
  logic [31:0] pollQ[$];
  logic [31:0] defaultDout = '0;
  logic        led1 = 1'b0, led2 = 1'b0;
  int          lastStrobeCyc = -10;

  dvc_bus_master #(.POLL_MAX(16'd5), .POLL_GAP(4'd2), .IDLE_CTL(IDLE_CTL)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cmd_mask(cmd_mask), .cmd_match(cmd_match), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout), .rsp_err(rsp_err),
    .bus_addr(bus_addr), .bus_mem_ctl(bus_mem_ctl), .bus_din(bus_din),
    .bus_dout(bus_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus_mem_ctl == DMEM_LW || bus_mem_ctl == DMEM_LBU) begin
      if (pollQ.size() > 0) bus_dout <= pollQ.pop_front();
      else bus_dout <= defaultDout;
    end
    if (bus_mem_ctl == DMEM_SW && bus_addr == CMD_ADDR) begin
      led1 <= bus_din[5];
      led2 <= bus_din[6];
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (bus_mem_ctl !== IDLE_CTL) begin
        strobe_t s;
        checks++;
        if (cyc == lastStrobeCyc + 1) begin
          errors++;
          $display("[TB] FAIL adjacent_strobe cyc=%0d", cyc);
        end
        lastStrobeCyc = cyc;
        if (strobeQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_strobe ctl=%0d addr=%h cyc=%0d", bus_mem_ctl, bus_addr, cyc);
        end else begin
          s = strobeQ.pop_front();
          if (bus_mem_ctl !== s.ctl || bus_addr !== s.addr || bus_din !== s.din || cyc != s.cyc) begin
            errors++;
            $display("[TB] FAIL strobe got ctl=%0d addr=%h din=%h cyc=%0d want ctl=%0d addr=%h din=%h cyc=%0d",
                     bus_mem_ctl, bus_addr, bus_din, cyc, s.ctl, s.addr, s.din, s.cyc);
          end
        end
      end else begin
        checks++;
        if (bus_din !== 32'b0) begin
          errors++;
          $display("[TB] FAIL idle_din got=%h want=0", bus_din);
        end
      end
      if (rsp_valid === 1'b1) begin
        rsp_t r;
        checks++;
        if (rspQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_rsp rdata=%h cyc=%0d", rsp_rdata, cyc);
        end else begin
          r = rspQ.pop_front();
          if (rsp_rdata !== r.rdata || rsp_timeout !== r.to || rsp_err !== r.err || cyc != r.cyc) begin
            errors++;
            $display("[TB] FAIL rsp got rdata=%h to=%b err=%b cyc=%0d want rdata=%h to=%b err=%b cyc=%0d",
                     rsp_rdata, rsp_timeout, rsp_err, cyc, r.rdata, r.to, r.err, r.cyc);
          end
        end
      end
    end
  end

  // Issue one command; queue its strobes (period 4) and, if lat > 0, its response
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] mask, input logic [31:0] match,
                               input int nStrobes, input logic [3:0] ctl, input logic [31:0] din,
                               input int lat, input logic [31:0] expRdata, input logic expTo,
                               input logic expErr, output int e0);
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL ready_wait got=%b want=1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wdata;
    cmd_mask = mask; cmd_match = match;
    @(posedge clk);
    #1;
    e0 = cyc;
    cmd_valid = 1'b0;
    for (int i = 0; i < nStrobes; i++) strobeQ.push_back('{ctl, addr, din, e0 + 4 * i});
    if (lat > 0) rspQ.push_back('{expRdata, expTo, expErr, e0 + lat - 1});
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ready_after_accept got=%b want=0", cmd_ready);
    end
  endtask

  task automatic checkOutput;
    int n = 0;
    while ((rspQ.size() > 0 || strobeQ.size() > 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rspQ.size() > 0 || strobeQ.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain got rsp=%0d strobes=%0d pending want=0", rspQ.size(), strobeQ.size());
      rspQ.delete();
      strobeQ.delete();
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'b0 || rsp_timeout !== 1'b0 ||
        rsp_err !== 1'b0 || bus_addr !== 32'b0 || bus_mem_ctl !== IDLE_CTL || bus_din !== 32'b0) begin
      errors++;
      $display("[TB] FAIL reset_values got rdy=%b v=%b d=%h to=%b err=%b a=%h ctl=%0d din=%h want 1 0 0 0 0 0 %0d 0",
               cmd_ready, rsp_valid, rsp_rdata, rsp_timeout, rsp_err, bus_addr, bus_mem_ctl, bus_din, IDLE_CTL);
    end
    rst = 1'b1;
  endtask

  task automatic test_store;
    int e0;
    applyStimulus(3'd1, CMD_ADDR, 32'h0000_0060, '0, '0, 1, DMEM_SW, 32'h60, 2, 32'h0, 1'b0, 1'b0, e0);
    checkOutput();
    checks++;
    if (led1 !== 1'b1 || led2 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL leds got=%b%b want=11", led1, led2);
    end
    applyStimulus(3'd3, UART_DATA_ADDR, 32'hDEAD_BE7E, '0, '0, 1, DMEM_SB, 32'h7E, 2, 32'h0, 1'b0, 1'b0, e0);
    checkOutput();
  endtask

  task automatic test_loads;
    int e0;
    defaultDout = 32'hFFFF_FFA5;
    applyStimulus(3'd2, UART_DATA_ADDR, '0, '0, '0, 1, DMEM_LBU, 32'h0, 3, 32'h0000_00A5, 1'b0, 1'b0, e0);
    checkOutput();
    defaultDout = 32'h1234_5678;
    applyStimulus(3'd0, STATUS_ADDR, 32'hFFFF_FFFF, '0, '0, 1, DMEM_LW, 32'h0, 3, 32'h1234_5678, 1'b0, 1'b0, e0);
    checkOutput();
  endtask

  task automatic test_poll;
    int e0;
    pollQ = '{32'h4, 32'h4, 32'h4, 32'h0};
    defaultDout = 32'h4;
    applyStimulus(3'd4, STATUS_ADDR, '0, 32'h4, 32'h0, 4, DMEM_LW, 32'h0, 15, 32'h0, 1'b0, 1'b0, e0);
    checkOutput();
    applyStimulus(3'd4, STATUS_ADDR, '0, 32'h4, 32'h0, 5, DMEM_LW, 32'h0, 19, 32'h4, 1'b1, 1'b0, e0);
    checkOutput();
  endtask

  task automatic test_illegal;
    int e0;
    applyStimulus(3'd6, CMD_ADDR, 32'h55, '0, '0, 0, IDLE_CTL, 32'h0, 1, 32'h0, 1'b0, 1'b1, e0);
    checkOutput();
    applyStimulus(3'd7, CMD_ADDR, 32'h55, '0, '0, 0, IDLE_CTL, 32'h0, 1, 32'h0, 1'b0, 1'b1, e0);
    checkOutput();
  endtask

  task automatic test_back_to_back;
    int e0a, e0b;
    applyStimulus(3'd1, CMD_ADDR, 32'h0000_0000, '0, '0, 1, DMEM_SW, 32'h0, 2, 32'h0, 1'b0, 1'b0, e0a);
    applyStimulus(3'd1, CMD_ADDR, 32'h0000_0060, '0, '0, 1, DMEM_SW, 32'h60, 2, 32'h0, 1'b0, 1'b0, e0b);
    checkOutput();
    checks++;
    if (e0b - e0a != 3) begin
      errors++;
      $display("[TB] FAIL back_to_back_spacing got=%0d want=3", e0b - e0a);
    end
  endtask

  task automatic test_reset_mid_poll;
    int e0;
    defaultDout = 32'h4;
    applyStimulus(3'd4, STATUS_ADDR, '0, 32'h4, 32'h0, 1, DMEM_LW, 32'h0, 0, 32'h0, 1'b0, 1'b0, e0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || bus_mem_ctl !== IDLE_CTL || rsp_valid !== 1'b0 || bus_addr !== 32'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_poll got rdy=%b ctl=%0d v=%b a=%h want 1 %0d 0 0",
               cmd_ready, bus_mem_ctl, rsp_valid, bus_addr, IDLE_CTL);
    end
    rst = 1'b1;
    repeat (25) @(negedge clk);
    checkOutput();
  endtask

  initial begin
    test_reset();
    test_store();
    test_loads();
    test_poll();
    test_illegal();
    test_back_to_back();
    test_reset_mid_poll();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dvc_bus_master.md
# dvc_bus_master

Bus initiator for the device-controller data bus (`addr` / `mem_ctl` / `din` / `dout`). It takes single commands over a valid/ready port and turns each one into a one-cycle load or store strobe. For reads it captures the responder's registered read data one cycle later. It also runs a hardware poll loop (for example, wait for UART `txd_busy` = 0 at `STATUS_ADDR`), so a loader or DMA engine can drive peripherals without the CPU. It sits beside the CPU data port, muxed onto the same device bus.

## Interface
Parameters:
- `POLL_MAX`, 16'd1000: maximum poll reads before the poll command ends with a timeout.
- `POLL_GAP`, 4'd2: idle cycles between consecutive poll reads (0 is legal).
- `IDLE_CTL`, 4'd0: `mem_ctl` code driven when no access is in progress. It must differ from `DMEM_SB`, `DMEM_SW`, `DMEM_LW`, `DMEM_LBU` and `DMEM_LBS`.

Ports:
- `clk` in 1: clock. All logic is on the rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command. High only in IDLE.
- `cmd_op` in 3: 0=LW, 1=SW, 2=LBU, 3=SB, 4=POLL; 5–7 are illegal.
- `cmd_addr` in 32: device address.
- `cmd_wdata` in 32: store data. Only bits [7:0] are used for SB.
- `cmd_mask` in 32: POLL compare mask.
- `cmd_match` in 32: POLL compare value.
- `rsp_valid` out 1: one-cycle response pulse. There is no backpressure.
- `rsp_rdata` out 32: read data. 0 for stores.
- `rsp_timeout` out 1: POLL exhausted `POLL_MAX` reads. Qualified by `rsp_valid`.
- `rsp_err` out 1: illegal op. Qualified by `rsp_valid`.
- `bus_addr` out 32: device address.
- `bus_mem_ctl` out 4: `DMEM_*` access code.
- `bus_din` out 32: write data to the device.
- `bus_dout` in 32: registered read data from the device. It is valid in the cycle after the access cycle.

## Operation
- The FSM has five states: IDLE, ISSUE, CAPT, RESP, GAP. All outputs are registered.
- **IDLE:** `cmd_ready` = 1. On `cmd_valid` & `cmd_ready`, latch op, addr, wdata, mask and match, clear the poll counter, and go to:
  - ISSUE for a legal op;
  - RESP with `rsp_err` = 1 for an illegal op. No bus access takes place.
- **ISSUE:** lasts exactly one cycle with the bus driven as follows.
  - `bus_addr` = latched addr.
  - `bus_mem_ctl`: LW/POLL → `DMEM_LW`, SW → `DMEM_SW`, LBU → `DMEM_LBU`, SB → `DMEM_SB`.
  - `bus_din`: wdata for SW; {24'b0, wdata[7:0]} for SB; 0 for reads.
  - Next state: stores → RESP; reads → CAPT.
- **CAPT:** the bus is idle. Sample `bus_dout` at the end of the cycle.
  - LW / POLL data = the full 32 bits. LBU data = {24'b0, `bus_dout`[7:0]}.
  - LW / LBU → RESP.
  - POLL, and (`bus_dout` & mask) == (match & mask) → RESP with the sampled data.
  - POLL, no match, and the incremented count == `POLL_MAX` → RESP with `rsp_timeout` = 1 and `rsp_rdata` = last sample.
  - POLL, no match otherwise → GAP. If `POLL_GAP` = 0, go straight to ISSUE.
- **GAP:** the bus is idle for `POLL_GAP` cycles, then ISSUE.
- **RESP:** `rsp_valid` = 1 for one cycle, with `rsp_rdata`, `rsp_timeout` and `rsp_err` valid. Then IDLE.
- **Idle bus:** in every state other than ISSUE, `bus_mem_ctl` = `IDLE_CTL`, `bus_din` = 0, and `bus_addr` holds its last value.
- **Counter:** the poll counter is 16 bits wide, saturates, and is compared after increment. `POLL_MAX` = 1 therefore means a single read.
- **Reset mid-operation:** go to IDLE and return all outputs to reset values. The pending command is dropped and no response is issued. An ISSUE cycle that coincides with the reset edge is not repeated.

## Timing
- **Reset values:** `cmd_ready` = 1; `rsp_valid` = 0; `rsp_rdata`, `rsp_timeout`, `rsp_err` = 0; `bus_addr` = 0; `bus_mem_ctl` = `IDLE_CTL`; `bus_din` = 0.
- **Latency,** with the command accepted at edge E0:
  - ISSUE occupies cycle E0+1.
  - Store: `rsp_valid` in cycle E0+2.
  - Read: `bus_dout` is sampled at the end of E0+2 and `rsp_valid` is in cycle E0+3.
  - Illegal op: `rsp_valid` in E0+1.
- **Poll period:** 2 + `POLL_GAP` cycles per attempt.
- **Back-to-back:** the next command can be accepted in the cycle after RESP. `cmd_ready` is low from acceptance through RESP.
- **Strobe width:** exactly one cycle with a non-idle `bus_mem_ctl` per access. No two access cycles are adjacent, so the responder's registered `dout` never overlaps.

## Test plan
- **SW:** SW to `CMD_ADDR` with wdata 0x0000_0060 → one ISSUE cycle with `DMEM_SW` and `bus_din` 0x60; `rsp_valid` at E0+2 with rdata 0; the responder's led1 and led2 both go high.
- **LBU:** LBU from `UART_DATA_ADDR` with the responder returning 0xFFFF_FFA5 → `rsp_rdata` 0x0000_00A5 at E0+3.
- **POLL match:** POLL `STATUS_ADDR`, mask 0x4, match 0; `bus_dout` = 0x4 for 3 reads, then 0x0 → 4 `DMEM_LW` strobes 4 cycles apart (with `POLL_GAP` = 2); `rsp_rdata` 0, `rsp_timeout` 0.
- **POLL timeout:** `POLL_MAX` = 5, `bus_dout` stuck at 0x4 → exactly 5 strobes, then `rsp_timeout` = 1 and `rsp_rdata` 0x4.
- **Illegal op:** op 6 → `rsp_valid` with `rsp_err` = 1 at E0+1; `bus_mem_ctl` stays `IDLE_CTL` throughout.
- **Reset mid-poll:** reset asserted during GAP → next cycle has `cmd_ready` = 1 and the bus idle; `rsp_valid` is never asserted for that command.
